// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: state encoding shared by the bit-serial adder controller
package serial_adder_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE,
    BAD  = 2'd3
  } state_e;
endpackage

// File: rtl/full_adder_gate.sv
// full_adder_gate: 1-bit gate-level full-adder cell
module full_adder_gate (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic p, g, t;
  xor (p, a, b);
  xor (sum, p, cin);
  and (g, a, b);
  and (t, p, cin);
  or  (cout, g, t);
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: sequences one full-adder cell over WIDTH cycles to add a + b + cin
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  state_e state, nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic [CNT_W-1:0] cnt;
  logic carry, fa_sum, fa_cout, load, last;
  full_adder_gate u_fa (
    .a(a_sh[0]),
    .b(b_sh[0]),
    .cin(carry),
    .sum(fa_sum),
    .cout(fa_cout)
  );
  assign busy  = state == RUN;
  assign ready = state == IDLE || state == DONE;
  assign done  = state == DONE;
  assign load  = ready && start;
  assign last  = busy && cnt == CNT_W'(WIDTH - 1);
  // the illegal encoding is neither busy nor ready, so it falls back to IDLE
  always_comb begin
    nxt = IDLE;
    if (busy) nxt = last ? DONE : RUN;
    else if (load) nxt = RUN;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      state <= nxt;
      if (load) begin
        a_sh  <= a;
        b_sh  <= b;
        carry <= cin;
        cnt   <= '0;
      end else if (busy) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        res_sh <= {fa_sum, res_sh[WIDTH-1:1]};
        carry  <= fa_cout;
        cnt    <= cnt + CNT_W'(1);
      end
      if (last) begin
        sum  <= {fa_sum, res_sh[WIDTH-1:1]};
        cout <= fa_cout;
      end
    end
  end
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial addition controller. Sequences a single 1-bit full-adder cell over WIDTH cycles to add two WIDTH-bit operands plus carry-in.
- Start/done handshake with a single requester. Sits between a requesting block and one shared full-adder datapath cell.
- Trades latency for area: one adder cell in place of a WIDTH-bit ripple adder.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH)+1, bit-counter width; derived, not overridden.

Ports:
- clk    input   1      rising-edge clock; the only clock.
- rst_n  input   1      synchronous, active-low reset.
- start  input   1      request; sampled only while ready=1.
- a      input   WIDTH  operand A; captured on accepted start.
- b      input   WIDTH  operand B; captured on accepted start.
- cin    input   1      carry-in; captured on accepted start.
- ready  output  1      controller can accept start (IDLE or DONE).
- busy   output  1      addition in progress (RUN).
- done   output  1      one-cycle pulse; sum/cout valid from this cycle.
- sum    output  WIDTH  registered result; held until the next completion.
- cout   output  1      registered final carry; held until the next completion.

Behaviour:
- Reset: one clock; reset is synchronous and active-low.
  - rst_n=0 sampled at a rising edge forces state=IDLE, sum=0, cout=0, done=0, busy=0, internal shift registers/counter/carry=0.
  - ready=1 from the first cycle after reset.
- States: IDLE, RUN, DONE. Outputs are decoded from state: busy=(RUN), ready=(IDLE|DONE), done=(DONE).
- IDLE:
  - start=1 -> load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, state<=RUN.
  - Otherwise stay in IDLE.
- RUN, each cycle:
  - Full-adder cell inputs are a_sh[0], b_sh[0], carry.
  - res_sh <= {fa_sum, res_sh[WIDTH-1:1]} (LSB-first result, shifted in at MSB).
  - a_sh and b_sh shift right by 1; carry <= fa_cout; cnt <= cnt+1.
  - When cnt==WIDTH-1: sum <= {fa_sum, res_sh[WIDTH-1:1]}, cout <= fa_cout, state <= DONE.
- DONE (exactly one cycle):
  - start=1 -> accepted exactly as in IDLE (back-to-back, no bubble), state<=RUN.
  - Otherwise state<=IDLE.
- Latency and throughput:
  - start sampled at edge E0 -> busy high for cycles E0..E(WIDTH-1).
  - done high in the single cycle after edge E(WIDTH), i.e. WIDTH+1 cycles after start.
  - Back-to-back throughput is one result per WIDTH+1 cycles.
- start while busy=1: ignored. No queuing, no effect on the in-flight operation.
- Operands a/b/cin may change freely after acceptance. Only the captured copies are used.
- sum/cout do not change during RUN. They update only on the RUN->DONE transition.
- Arithmetic: {cout,sum} == a + b + cin, modulo 2^(WIDTH+1) (exact).
- Reset mid-RUN: operation is aborted. No done pulse, sum/cout cleared to 0, state IDLE.
- start=1 while rst_n=0: ignored; reset has priority.

Decomposition:
- Shared package serial_adder_pkg:
  - State encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - 2'd3 is illegal and recovers to IDLE.
- One sub-module instance: full_adder_gate, the team's existing 1-bit gate-level cell (ports a, b, cin, sum, cout). Used unchanged as the datapath.
- The controller holds all state: FSM, shift registers, carry flop, counter.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with start=1 -> ready=1, busy=0, done=0, sum=0, cout=0; no operation starts.
- WIDTH=8, a=8'hFF, b=8'h01, cin=0, one start pulse -> busy for 8 cycles; done pulse 9 cycles after start; sum=8'h00, cout=1.
- a=8'h5A, b=8'h25, cin=1 -> sum=8'h80, cout=0. Operands are changed to 8'h00 one cycle after start; the result is unaffected.
- Start 8'h10+8'h01 (cin=0). Pulse start again with 8'hAA+8'h55 at RUN cycle 3 -> second request ignored; sum=8'h11; only one done pulse.
- Back-to-back: start held high continuously with 8'h0F+8'h01, then 8'hF0+8'h10 presented on the DONE cycle.
  - First done gives sum=8'h10, cout=0.
  - Second done follows 9 cycles later with sum=8'h00, cout=1.
- Reset mid-op: rst_n=0 at RUN cycle 4 of 8'h7F+8'h7F -> next cycle state IDLE, busy=0, sum=0, cout=0; no done. A fresh start afterwards yields sum=8'hFE, cout=0.
